// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the fifo_rd_stream drain stage.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read-side and output-stream signals of fifo_rd_stream.
// master = the drain stage, slave = FIFO plus downstream consumer.
interface fifo_rd_stream_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] fifo_d_out;
  logic              fifo_empty;
  logic              fifo_r_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  fifo_d_out, fifo_empty, out_ready,
    output fifo_r_en, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_d_out, fifo_empty, out_ready,
    input  fifo_r_en, out_data, out_valid, out_last
  );

endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// rd_skid_buf: 2-entry FIFO-ordered register buffer. An incoming word is
// visible at the head in its arrival cycle when the buffer is empty.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [OCC_W-1:0]  count
);

  logic [SKID_DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [SKID_DEPTH-1:0][DATA_W-1:0] w_mem_nx;
  logic [OCC_W-1:0]                  r_count;
  logic [OCC_W-1:0]                  w_cnt_nx;

  assign head_valid = (r_count != '0) | push;
  assign head_data  = (r_count != '0) ? r_mem[0] : (push ? push_data : '0);
  assign count      = r_count;

  // Pop shifts entry 1 forward first; a push then lands behind what remains.
  // A push into an empty buffer that is popped at once passes straight through.
  always_comb begin
    w_mem_nx = r_mem;
    w_cnt_nx = r_count;
    if (pop && (r_count != '0)) begin
      w_mem_nx[0] = r_mem[1];
      w_mem_nx[1] = '0;
      w_cnt_nx    = r_count - OCC_W'(1);
    end
    if (push && !(pop && (r_count == '0))) begin
      w_mem_nx[w_cnt_nx[0]] = push_data;
      w_cnt_nx              = w_cnt_nx + OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem   <= '0;
      r_count <= '0;
    end else begin
      r_mem   <= w_mem_nx;
      r_count <= w_cnt_nx;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (r_count == OCC_W'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains len words from a 1-cycle-latency FIFO onto a
// valid/ready stream with last marker. Optional: FIFO_RD_STALL_CNT_EN adds stall_cnt.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
`ifdef FIFO_RD_STALL_CNT_EN
  output logic [31:0]      stall_cnt,
`endif
  fifo_rd_stream_if.master bus
);

  state_t            r_state;
  state_t            w_state_nx;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_sent;
  logic              r_pend;
  logic              w_start_acc;
  logic              w_rd_en;
  logic              w_pop;
  logic [OCC_W-1:0]  w_skid_cnt;
  logic [OCC_W-1:0]  w_occ;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_valid;

  assign w_start_acc = (r_state == IDLE) & start;
  assign w_pop       = w_head_valid & bus.out_ready;
  // In-flight read counts as occupied so the buffer can always absorb it.
  assign w_occ       = w_skid_cnt + OCC_W'(r_pend);
  assign w_rd_en     = (r_state == RUN) & ~bus.fifo_empty & (r_issued < r_len) &
                       ((w_occ < OCC_W'(SKID_DEPTH)) | w_pop);

  assign bus.fifo_r_en = w_rd_en;
  assign bus.out_valid = w_head_valid;
  assign bus.out_data  = w_head_data;
  assign bus.out_last  = w_head_valid & (r_sent == (r_len - LEN_W'(1)));
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = (len == '0) ? DONE : RUN;
      RUN:     if (r_issued == r_len) w_state_nx = FLUSH;
      FLUSH:   if (r_sent == r_len) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len    <= '0;
      r_issued <= '0;
      r_sent   <= '0;
      r_pend   <= 1'b0;
    end else begin
      r_pend <= w_rd_en;
      if (w_start_acc) begin
        r_len    <= len;
        r_issued <= '0;
        r_sent   <= '0;
      end else begin
        if (w_rd_en) r_issued <= r_issued + LEN_W'(1);
        if (w_pop)   r_sent   <= r_sent + LEN_W'(1);
      end
    end
  end

  rd_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (r_pend),
    .push_data  (bus.fifo_d_out),
    .pop        (w_pop),
    .head_data  (w_head_data),
    .head_valid (w_head_valid),
    .count      (w_skid_cnt)
  );

`ifdef FIFO_RD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (w_head_valid && !bus.out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: directed transfers against a modelled
// registered-read FIFO; expected words are queued at issue and checked on pop.
module tb_fifo_rd_stream;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 16;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [LEN_W-1:0] len     = '0;
  logic             busy;
  logic             done;
`ifdef FIFO_RD_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  fifo_rd_stream_if #(.DATA_W(DATA_W)) bus ();

  fifo_rd_stream #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
`ifdef FIFO_RD_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // FIFO model: registered read, zero data when not reading.
  logic [DATA_W-1:0] fmem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.fifo_r_en) begin
      bus.fifo_d_out <= fmem[rd_ptr];
      rd_ptr         <= rd_ptr + 1;
    end else begin
      bus.fifo_d_out <= '0;
    end
  end

  task automatic load(input logic [DATA_W-1:0] v);
    fmem[wr_ptr] = v;
    wr_ptr++;
  endtask

  // Scoreboard: {last, data}
  logic [DATA_W:0] exp_q [$];
  int rd_total = 0;
  int done_cnt = 0;

  task automatic expect_word(input logic [DATA_W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Monitor samples just before each rising edge, after inputs settle.
  int              occ        = 0;
  logic            prev_stall = 1'b0;
  logic [DATA_W:0] prev_word  = '0;

  always @(negedge clk) begin
    logic            pop;
    logic [DATA_W:0] e;
    #4;
    if (!reset_n) begin
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      pop = bus.out_valid && bus.out_ready;
      if (prev_stall) begin
        n_checks++;
        if (!bus.out_valid || ({bus.out_last, bus.out_data} !== prev_word)) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b word=0x%0h, expected valid=1 word=0x%0h",
                   bus.out_valid, {bus.out_last, bus.out_data}, prev_word);
        end
      end
      if (bus.fifo_r_en) begin
        n_checks++;
        if (bus.fifo_empty || (occ >= 2 && !pop)) begin
          n_fail++;
          $display("FAIL rd_en_legal: got r_en=1 empty=%0b occ=%0d pop=%0b, expected empty=0 and room",
                   bus.fifo_empty, occ, pop);
        end
      end
      if (pop) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: got word 0x%0h, expected no output", {bus.out_last, bus.out_data});
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            n_fail++;
            $display("FAIL sb_word: got {last,data}=0x%0h, expected 0x%0h",
                     {bus.out_last, bus.out_data}, e);
          end
        end
      end
      if (done) done_cnt++;
      if (bus.fifo_r_en) begin
        occ++;
        rd_total++;
      end
      if (pop) occ--;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
    end
  end

  task automatic start_xfer(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready=1; 1: ready 1,0,0,1; 2: feed FIFO every 5 cycles; 3: extra start
  task automatic wait_done(input string nm, input int mode, input bit lat);
    bit seen   = 1'b0;
    int pushed = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (lat && cyc == 0) begin
        check({nm, "_lat_rd_en"}, 32'(bus.fifo_r_en), 32'd1);
        check({nm, "_busy"}, 32'(busy), 32'd1);
      end
      if (lat && cyc >= 1 && cyc <= 4) check({nm, "_valid_run"}, 32'(bus.out_valid), 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      case (mode)
        1: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2: if ((cyc % 5) == 0 && pushed < 3) begin
             load(8'h31 + 8'(pushed));
             pushed++;
           end
        3: begin
             start = (cyc == 1);
             len   = (cyc == 1) ? 16'd9 : len;
           end
        default: bus.out_ready = 1'b1;
      endcase
      @(negedge clk);
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    start         = 1'b0;
    bus.out_ready = 1'b1;
    if (seen) begin
      @(negedge clk);
      check({nm, "_done_once"}, 32'(done), 32'd0);
      check({nm, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic post_checks(input string nm, input int rd0, input int d0, input int n_rd);
    check({nm, "_reads"}, 32'(rd_total - rd0), 32'(n_rd));
    check({nm, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int rd0;
    int d0;
    bit seen_v;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(bus.fifo_r_en), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic transfer
    for (int i = 0; i < 4; i++) begin
      load(8'h11 + 8'(i));
      expect_word(8'h11 + 8'(i), i == 3);
    end
    rd0 = rd_total; d0 = done_cnt;
    start_xfer(16'd4);
    wait_done("basic", 0, 1'b1);
    post_checks("basic", rd0, d0, 4);

    // Backpressure
    for (int i = 0; i < 6; i++) begin
      load(8'h21 + 8'(i));
      expect_word(8'h21 + 8'(i), i == 5);
    end
    rd0 = rd_total; d0 = done_cnt;
    start_xfer(16'd6);
    wait_done("bp", 1, 1'b0);
    post_checks("bp", rd0, d0, 6);

    // Empty FIFO, trickle feed
    for (int i = 0; i < 3; i++) expect_word(8'h31 + 8'(i), i == 2);
    rd0 = rd_total; d0 = done_cnt;
    start_xfer(16'd3);
    wait_done("empty", 2, 1'b0);
    post_checks("empty", rd0, d0, 3);

    // len = 0
    rd0 = rd_total; d0 = done_cnt;
    start_xfer(16'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_rd_en", 32'(bus.fifo_r_en), 32'd0);
    check("len0_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("len0_done_once", 32'(done), 32'd0);
    check("len0_reads", 32'(rd_total - rd0), 32'd0);
    check("len0_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Start while busy is ignored
    for (int i = 0; i < 3; i++) begin
      load(8'h41 + 8'(i));
      expect_word(8'h41 + 8'(i), i == 2);
    end
    rd0 = rd_total; d0 = done_cnt;
    start_xfer(16'd3);
    wait_done("restart", 3, 1'b0);
    post_checks("restart", rd0, d0, 3);

    // Reset mid-transfer with the skid buffer full
    for (int i = 0; i < 6; i++) begin
      load(8'h51 + 8'(i));
      expect_word(8'h51 + 8'(i), i == 5);
    end
    bus.out_ready = 1'b0;
    start_xfer(16'd6);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rd_en", 32'(bus.fifo_r_en), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_last", 32'(bus.out_last), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    #2;
    exp_q.delete();
    bus.out_ready = 1'b1;
    reset_n       = 1'b1;
    @(negedge clk);
    expect_word(8'h53, 1'b0);
    expect_word(8'h54, 1'b1);
    rd0 = rd_total; d0 = done_cnt;
    start_xfer(16'd2);
    wait_done("after_rst", 0, 1'b0);
    post_checks("after_rst", rd0, d0, 2);

`ifdef FIFO_RD_STALL_CNT_EN
    // 7-cycle stall on a single word
    expect_word(8'h55, 1'b1);
    rd0 = rd_total; d0 = done_cnt;
    bus.out_ready = 1'b0;
    start_xfer(16'd1);
    seen_v = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        seen_v = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("stall_valid_seen", 32'(seen_v), 32'd1);
    repeat (7) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("stall_cnt", stall_cnt, 32'd7);
    wait_done("stall", 0, 1'b0);
    post_checks("stall", rd0, d0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Output-side drain stage placed directly downstream of the coprocessor output FIFO (a_fifo).
- On a start pulse it pops exactly len words from the FIFO and absorbs the FIFO's 1-cycle registered read latency.
- Presents the words on a valid/ready stream with a last marker, then pulses done.
- The 2-entry skid buffer gives full throughput under backpressure without losing words.

Parameters:
- DATA_W, 8: data width; equals the FIFO f_width.
- LEN_W, 16: width of the transfer-length input and the internal counters.

Ports:
- clk  in  1  single clock; the FIFO read side runs on the same clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a transfer (sampled in IDLE only).
- len  in  LEN_W  number of words to transfer; sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of transfer.
- fifo_d_out  in  DATA_W  FIFO read data; valid the cycle after fifo_r_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_en  out  1  FIFO read enable.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  high with the final word of the transfer.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, fifo_r_en, out_valid, out_last=0; out_data=0; counters, occupancy and skid entries cleared.
- Reset mid-transfer: remaining words are abandoned; the in-flight FIFO read word is discarded.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: start=1 and len!=0 -> RUN, latching len.
  - IDLE: start=1 and len==0 -> DONE; no FIFO reads occur.
  - RUN: when issued==len, -> FLUSH.
  - FLUSH: when sent==len, -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
  - busy=1 in RUN, FLUSH and DONE.
  - start is ignored outside IDLE.
- pop = out_valid & out_ready.
- occ (0..2) counts words held in the skid buffer plus at most one FIFO read in flight.
- fifo_r_en = (state==RUN) & !fifo_empty & (issued<len) & (occ<2 | pop). It is combinational and never asserted while fifo_empty=1.
- Read capture: a pending flag is registered on fifo_r_en. fifo_d_out is written into the skid buffer in the following cycle, whatever fifo_r_en is in that cycle. The FIFO zeroes d_out when not reading, so fifo_d_out is never sampled in any other cycle.
- Skid buffer:
  - FIFO ordering; out_data/out_valid come from the head entry.
  - Simultaneous capture and pop is allowed in any occupancy.
  - Overflow cannot occur by construction; an assertion checks this.
- Latency: first fifo_r_en in the cycle after start (if not empty); first out_valid 2 cycles after start.
- Steady-state throughput with out_ready=1: one word per cycle.
- Stream rules:
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a pop.
- out_last = out_valid & (sent==len-1).
- Counters: issued increments on fifo_r_en and sent increments on pop. Both are LEN_W wide, reset on start, and never wrap (bounded by len).
- len = 2^LEN_W-1 is supported.

Optional Feature:
- Macro FIFO_RD_STALL_CNT_EN.
- When defined, adds output port stall_cnt (out, 32 bits):
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset and by an accepted start.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fifo_rd_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DONE);
  - SKID_DEPTH=2 constant;
  - occupancy width constant.
- One sub-module, rd_skid_buf:
  - 2-entry FIFO-ordered register buffer;
  - ports: push/push_data, pop, head_data, head_valid, count.
- FSM, counters and fifo_r_en generation stay in the top level.

Test Plan:
- Basic transfer: FIFO preloaded with 0x11..0x14, len=4, out_ready=1 -> out_data 11,12,13,14 on consecutive cycles; out_last only with 0x14; done pulses once; exactly 4 fifo_r_en cycles.
- Backpressure: len=6, out_ready toggles 1,0,0,1 repeating -> words in order with none lost or duplicated; out_data stable while stalled; occ never exceeds 2; fifo_r_en=0 whenever occ==2 and no pop.
- Empty FIFO: len=3 with FIFO empty, push one word every 5 cycles -> fifo_r_en=1 only when fifo_empty=0; 3 words out; done after the third pop.
- len=0: start -> done pulses the next cycle; fifo_r_en and out_valid stay 0.
- Start while busy: start again mid-transfer with len=9 -> ignored; original len completes.
- Reset mid-transfer: reset_n=0 mid-transfer (occ=2) -> all outputs 0 immediately (async); after release a new len=2 transfer completes cleanly. With FIFO_RD_STALL_CNT_EN, a 7-cycle stall gives stall_cnt=7.
